// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch output arbiter.
package switch_arb_pkg;

  // Output scheduler FSM: grant, read strobe, capture, present downstream.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } arb_state_e;

  // Width of a port index; never narrower than one bit.
  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: first set request at or after
// i_start (wrapping). With i_start tied to 0 it is a plain fixed-priority
// encoder, lowest index wins.
module rr_pick
  import switch_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = port_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_grant,
  output logic          o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Walk the requests from i_start, modulo N, and keep the first hit.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    o_grant = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_start} + (IW + 1)'(i);
      if (w_sum >= (IW + 1)'(N)) begin
        w_sum = w_sum - (IW + 1)'(N);
      end
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any   = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Output-side scheduler: grants one switch port at a time, strobes its read
// line once per word, captures the returned word and forwards it on a single
// valid/ready stream tagged with the source port. A grant drains at most
// MAX_BURST words.
// Build option: define SWITCH_ARB_FIXED_PRIO_EN for fixed priority (lowest
// ready port wins); the default build arbitrates round-robin.
module switch_out_arbiter
  import switch_arb_pkg::*;
#(
  parameter  int NUM_OF_PORTS = 4,
  parameter  int WORD_WIDTH   = 8,
  parameter  int MAX_BURST    = 4,
  localparam int PW           = port_idx_w(NUM_OF_PORTS),
  localparam int BW           = $clog2(MAX_BURST + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic [WORD_WIDTH-1:0]              arb_data,
  output logic [PW-1:0]                      arb_port,
  output logic                               arb_last,
  output logic                               arb_valid,
  input  logic                               arb_ready
);

  arb_state_e            r_state;
  arb_state_e            w_next;
  logic [PW-1:0]         r_grant;
  logic [BW-1:0]         r_burst_cnt;
  logic [WORD_WIDTH-1:0] r_data;
  logic [PW-1:0]         r_port;
  logic                  r_last;

  logic [PW-1:0]         w_start;
  logic [PW-1:0]         w_pick;
  logic                  w_any;
  logic                  w_xfer;
  logic                  w_burst_end;
  logic [WORD_WIDTH-1:0] w_port_word [NUM_OF_PORTS];

  for (genvar gi = 0; gi < NUM_OF_PORTS; gi++) begin : g_unpack
    assign w_port_word[gi] = port_out[gi*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef SWITCH_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [PW-1:0] r_last_grant;

  // Remember the port of the last completed grant; reset makes port 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PW'(NUM_OF_PORTS - 1);
    end else if (w_xfer && r_last) begin
      r_last_grant <= r_grant;
    end
  end

  assign w_start = (r_last_grant == PW'(NUM_OF_PORTS - 1)) ? '0
                                                           : r_last_grant + PW'(1);
`endif

  rr_pick #(
    .N  (NUM_OF_PORTS),
    .IW (PW)
  ) u_pick (
    .i_req   (port_ready),
    .i_start (w_start),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  assign w_xfer      = (r_state == OUT) && arb_ready;
  assign w_burst_end = (r_burst_cnt == BW'(MAX_BURST - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; enable only gates the start of a grant.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (enable && w_any) w_next = RD;
      RD:      w_next = CAP;
      CAP:     w_next = OUT;
      OUT:     if (w_xfer) w_next = r_last ? IDLE : RD;
      default: w_next = IDLE;
    endcase
  end

  // Grant, burst counter and output word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_data      <= '0;
      r_port      <= '0;
      r_last      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (enable && w_any) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
          end
        end
        CAP: begin
          // port_ready[g] here already reflects the word just read.
          r_data <= w_port_word[r_grant];
          r_port <= r_grant;
          r_last <= w_burst_end || !port_ready[r_grant];
        end
        OUT: begin
          if (w_xfer && !r_last) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot read strobe, only while in RD.
  always_comb begin
    port_read = '0;
    if (r_state == RD) begin
      port_read[r_grant] = 1'b1;
    end
  end

  assign arb_valid = (r_state == OUT);
  assign arb_data  = r_data;
  assign arb_port  = r_port;
  assign arb_last  = r_last;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Self-checking bench for switch_out_arbiter: a queue-based model of the
// switch ports, a directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference.
module tb_switch_out_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           arb_ready;
  logic [N-1:0]   port_ready;
  logic [N-1:0]   port_read;
  logic [N*W-1:0] port_out;
  logic [W-1:0]   arb_data;
  logic [1:0]     arb_port;
  logic           arb_last;
  logic           arb_valid;

  always #5 clk = ~clk;

  switch_out_arbiter #(
    .NUM_OF_PORTS (N),
    .WORD_WIDTH   (W),
    .MAX_BURST    (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .port_ready (port_ready),
    .port_out   (port_out),
    .port_read  (port_read),
    .arb_data   (arb_data),
    .arb_port   (arb_port),
    .arb_last   (arb_last),
    .arb_valid  (arb_valid),
    .arb_ready  (arb_ready)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } xfer_t;

  typedef struct {
    logic [N-1:0] rd;
    int           cyc;
  } rd_t;

  typedef struct {
    int cnt [N];
    int exp_port;
    int exp_len;
  } vec_t;

  xfer_t      xfers [$];
  rd_t        reads [$];
  logic [7:0] q [N][$];
  logic [7:0] pout [N] = '{default: 8'h00};
  logic [N-1:0] ready_r = '0;
  int         cyc = 0;
  int         ready_rise_cyc = -1;
  logic [N-1:0] prev_ready = '0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Switch port model: a read pops the head word, visible one cycle later;
  // ready falls in the cycle after the read that emptied the port.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (port_read[i] && q[i].size() != 0) pout[i] <= q[i].pop_front();
      ready_r[i] <= (q[i].size() != 0);
    end
  end

  assign port_ready = ready_r;
  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign port_out[gi*W +: W] = pout[gi];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge: log transfers and reads, and
  // check the stream protocol every cycle.
  always @(negedge clk) begin
    if (arb_valid && arb_ready) xfers.push_back('{int'(arb_port), arb_data, arb_last, cyc});
    if (port_read != '0) reads.push_back('{port_read, cyc});
    if (port_ready != '0 && prev_ready == '0) ready_rise_cyc <= cyc;
    prev_ready <= port_ready;
    check("read_onehot", 32'($onehot0(port_read)), 1);
    check("read_while_valid", 32'((|port_read) && arb_valid), 0);
    if (prev_hold && !rst) begin
      check("hold_valid", 32'(arb_valid), 1);
      check("hold_data", 32'(arb_data), 32'(prev_data));
    end
    prev_hold <= arb_valid && !arb_ready && !rst;
    prev_data <= arb_data;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic xfer_t get_x(input int i);
    xfer_t z = '{-1, 8'h00, 1'b0, -1};
    if (i < xfers.size()) return xfers[i];
    return z;
  endfunction

  function automatic rd_t get_r(input int i);
    rd_t z = '{'0, -1};
    if (i < reads.size()) return reads[i];
    return z;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    tick(3);
    xfers.delete();
    reads.delete();
    rst = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (xfers.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, 32'(xfers.size() >= n), 1);
  endtask

  vec_t       vecs [6];
  int         exp_c [5];
  xfer_t      x;
  rd_t        r;
  xfer_t      exp_q [$];
  logic [7:0] d [N][$];
  int         model_last;
  int         rem [N];
  int         k;

  initial begin
    vecs[0] = '{'{0, 2, 0, 0}, 1, 2};
    vecs[1] = '{'{3, 0, 0, 6}, 0, 3};
    vecs[2] = '{'{0, 0, 0, 6}, 3, 4};
    vecs[3] = '{'{1, 1, 1, 1}, 0, 1};
    vecs[4] = '{'{0, 0, 5, 0}, 2, 4};
    vecs[5] = '{'{0, 4, 1, 0}, 1, 4};
`ifdef SWITCH_ARB_FIXED_PRIO_EN
    exp_c = '{0, 0, 1, 2, 3};
`else
    exp_c = '{0, 1, 2, 3, 0};
`endif

    // Reset values.
    rst = 1'b1;
    enable = 1'b0;
    arb_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(arb_valid), 0);
    check("rst_read", 32'(port_read), 0);
    check("rst_last", 32'(arb_last), 0);
    check("rst_data", 32'(arb_data), 0);
    check("rst_port", 32'(arb_port), 0);
    rst = 1'b0;

    // Vector table: first grant after reset and its burst length.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      enable = 1'b1;
      arb_ready = 1'b1;
      for (int p = 0; p < N; p++)
        for (int j = 0; j < vecs[v].cnt[p]; j++) q[p].push_back(8'(p * 16 + j));
      wait_xfers(vecs[v].exp_len, 80, "vec");
      for (int j = 0; j < vecs[v].exp_len; j++) begin
        x = get_x(j);
        check("vec_port", x.port, vecs[v].exp_port);
        check("vec_data", 32'(x.data), 32'(vecs[v].exp_port * 16 + j));
        check("vec_last", 32'(x.last), 32'(j == vecs[v].exp_len - 1));
      end
    end

    // Port 1 alone with two words: latency, spacing and strobes.
    do_reset();
    enable = 1'b1;
    arb_ready = 1'b1;
    q[1].push_back(8'hA1);
    q[1].push_back(8'hA2);
    wait_xfers(2, 60, "p1");
    x = get_x(0);
    check("p1_w0_data", 32'(x.data), 32'hA1);
    check("p1_w0_last", 32'(x.last), 0);
    check("p1_w0_port", x.port, 1);
    r = get_r(0);
    check("p1_rd_lat", 32'(r.cyc - ready_rise_cyc), 1);
    check("p1_valid_lat", 32'(x.cyc - r.cyc), 2);
    check("p1_rd0", 32'(r.rd), 32'b0010);
    check("p1_rd1", 32'(get_r(1).rd), 32'b0010);
    x = get_x(1);
    check("p1_w1_data", 32'(x.data), 32'hA2);
    check("p1_w1_last", 32'(x.last), 1);
    check("p1_w1_port", x.port, 1);
    check("p1_spacing", 32'(x.cyc - get_x(0).cyc), 3);
    check("p1_nreads", 32'(reads.size()), 2);

    // Port 3 with six words: split into a 4-word and a 2-word grant.
    do_reset();
    enable = 1'b1;
    arb_ready = 1'b1;
    for (int j = 0; j < 6; j++) q[3].push_back(8'h30 + 8'(j));
    wait_xfers(6, 100, "p3");
    for (int j = 0; j < 6; j++) begin
      x = get_x(j);
      check("p3_port", x.port, 3);
      check("p3_data", 32'(x.data), 32'h30 + 32'(j));
      check("p3_last", 32'(x.last), 32'(j == 3 || j == 5));
    end

    // All ports ready; port 0 refilled during its first grant.
    do_reset();
    enable = 1'b1;
    arb_ready = 1'b1;
    for (int p = 0; p < N; p++) q[p].push_back(8'h40 + 8'(p));
    k = 0;
    while (reads.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    check("rr_first_read", 32'(reads.size() >= 1), 1);
    q[0].push_back(8'h4F);
    wait_xfers(5, 100, "rr");
    for (int j = 0; j < 5; j++) begin
      x = get_x(j);
      check("rr_port", x.port, exp_c[j]);
      check("rr_last", 32'(x.last), 1);
    end

    // Downstream stall for 10 cycles while a word is presented.
    do_reset();
    enable = 1'b1;
    arb_ready = 1'b0;
    q[2].push_back(8'h51);
    q[2].push_back(8'h52);
    k = 0;
    while (!arb_valid && k < 30) begin
      tick();
      k++;
    end
    check("stall_valid", 32'(arb_valid), 1);
    check("stall_data0", 32'(arb_data), 32'h51);
    check("stall_port", 32'(arb_port), 2);
    check("stall_last0", 32'(arb_last), 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("stall_hold_valid", 32'(arb_valid), 1);
      check("stall_hold_data", 32'(arb_data), 32'h51);
      check("stall_no_read", 32'(port_read), 0);
    end
    check("stall_nreads", 32'(reads.size()), 1);
    arb_ready = 1'b1;
    tick();
    check("stall_xfer_now", 32'(xfers.size()), 1);
    check("stall_valid_drop", 32'(arb_valid), 0);
    check("stall_xfer_data", 32'(get_x(0).data), 32'h51);
    wait_xfers(2, 30, "stall");
    check("stall_w1_data", 32'(get_x(1).data), 32'h52);
    check("stall_w1_last", 32'(get_x(1).last), 1);

    // Reset while port 2's word is pending in OUT.
    do_reset();
    enable = 1'b1;
    arb_ready = 1'b1;
    q[0].push_back(8'h10);
    wait_xfers(1, 30, "rmid_pre");
    arb_ready = 1'b0;
    tick(2);
    q[2].push_back(8'h22);
    k = 0;
    while (!(arb_valid && arb_port == 2'd2) && k < 30) begin
      tick();
      k++;
    end
    check("rmid_pending", 32'(arb_valid && arb_port == 2'd2), 1);
    rst = 1'b1;
    q[0].push_back(8'h30);
    q[1].push_back(8'h31);
    tick();
    check("rmid_valid", 32'(arb_valid), 0);
    check("rmid_read", 32'(port_read), 0);
    check("rmid_data", 32'(arb_data), 0);
    check("rmid_port", 32'(arb_port), 0);
    rst = 1'b0;
    arb_ready = 1'b1;
    xfers.delete();
    reads.delete();
    wait_xfers(1, 30, "rmid");
    check("rmid_next_port", get_x(0).port, 0);
    check("rmid_next_data", 32'(get_x(0).data), 32'h30);

    // enable low blocks grants; dropping it mid-burst lets the burst finish.
    do_reset();
    enable = 1'b0;
    arb_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      q[0].push_back(8'h60 + 8'(j));
      q[1].push_back(8'h70 + 8'(j));
    end
    tick(20);
    check("en_no_read", 32'(reads.size()), 0);
    check("en_no_valid", 32'(arb_valid), 0);
    enable = 1'b1;
    k = 0;
    while (reads.size() < 1 && k < 10) begin
      tick();
      k++;
    end
    enable = 1'b0;
    tick(40);
    check("en_nxfers", 32'(xfers.size()), 3);
    check("en_nreads", 32'(reads.size()), 3);
    for (int j = 0; j < 3; j++) begin
      x = get_x(j);
      check("en_port", x.port, 0);
      check("en_data", 32'(x.data), 32'h60 + 32'(j));
      check("en_last", 32'(x.last), 32'(j == 2));
    end

    // Randomized rounds against a transaction-level reference: ports are
    // loaded together while idle, then drained with random back-pressure.
    do_reset();
    model_last = N - 1;
    for (int round = 0; round < 10; round++) begin
      exp_q.delete();
      for (int p = 0; p < N; p++) begin
        d[p].delete();
        rem[p] = $urandom_range(0, 7);
        for (int j = 0; j < rem[p]; j++) begin
          d[p].push_back(8'($urandom));
          q[p].push_back(d[p][j]);
        end
      end
      // Reference: repeatedly pick the next port with words left, take up
      // to MB of them, mark the final one.
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
        int st;
        int g;
        int n;
`ifdef SWITCH_ARB_FIXED_PRIO_EN
        st = 0;
`else
        st = (model_last + 1) % N;
`endif
        g = -1;
        for (int i = 0; i < N; i++)
          if (g < 0 && rem[(st + i) % N] > 0) g = (st + i) % N;
        n = (rem[g] < MB) ? rem[g] : MB;
        for (int j = 0; j < n; j++) exp_q.push_back('{g, d[g].pop_front(), (j == n - 1), 0});
        rem[g] -= n;
        model_last = g;
      end
      enable = 1'b1;
      k = 0;
      while (xfers.size() < exp_q.size() && k < 600) begin
        tick();
        arb_ready = 1'($urandom_range(0, 1));
        k++;
      end
      arb_ready = 1'b1;
      tick(6);
      check("rnd_count", 32'(xfers.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
        x = get_x(j);
        check("rnd_port", x.port, exp_q[j].port);
        check("rnd_data", 32'(x.data), 32'(exp_q[j].data));
        check("rnd_last", 32'(x.last), 32'(exp_q[j].last));
      end
      xfers.delete();
      reads.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_out_arbiter.md
# switch_out_arbiter

Output-side scheduler for the switch. Watches the per-port ready flags, grants one port at a time, pulses that port's read strobe and captures the returned word. Each word is forwarded on a single valid/ready output stream, tagged with its source port. It sits between the switch's per-port outputs (`port_ready`, `port_read`, `port_out`) and one downstream consumer, and bounds each grant to `MAX_BURST` words for fairness.

## Interface
- `NUM_OF_PORTS`, 4: number of switch ports; must be ≥2.
- `WORD_WIDTH`, 8: data word width.
- `MAX_BURST`, 4: maximum words drained per grant; must be ≥1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: allows new grants; sampled in IDLE only.
- `port_ready` in NUM_OF_PORTS: port i holds at least one word.
- `port_out` in NUM_OF_PORTS*WORD_WIDTH: port i data in bits [i*W +: W]; valid 1 cycle after `port_read[i]`.
- `port_read` out NUM_OF_PORTS: one-hot read strobe, one cycle per word.
- `arb_data` out WORD_WIDTH: captured word.
- `arb_port` out $clog2(NUM_OF_PORTS): source port of `arb_data`.
- `arb_last` out 1: word is the final one of the current grant.
- `arb_valid` out 1: output word valid.
- `arb_ready` in 1: downstream accepts the word; transfer happens when `arb_valid && arb_ready`.

## Operation
- FSM states: IDLE, RD, CAP, OUT.
- **IDLE**
  - If `enable` and `|port_ready`: pick grant `g` (see Configuration), clear `burst_cnt`, go to RD.
  - Otherwise stay in IDLE.
- **RD**
  - `port_read[g]=1` for exactly this cycle; go to CAP.
- **CAP**
  - Register `arb_data <= port_out[g*W +: W]` and `arb_port <= g`.
  - Register `arb_last <= (burst_cnt==MAX_BURST-1) || !port_ready[g]`; go to OUT.
- **OUT**
  - `arb_valid=1`, with `arb_data`, `arb_port` and `arb_last` held stable.
  - On transfer with `arb_last`: update `last_grant <= g` and go to IDLE.
  - On transfer without `arb_last`: `burst_cnt++` and go to RD.
  - Without a transfer: stay in OUT indefinitely; no other port is read meanwhile.
- Contract on the switch side: `port_ready[i]` falls only in the cycle after `port_read[i]`. This makes the CAP-time sample of `port_ready[g]` exact for `arb_last`.
- `enable` falling mid-burst has no effect; the current burst completes.
- `burst_cnt` is $clog2(MAX_BURST+1) bits wide and never exceeds `MAX_BURST-1`.
- `port_read` is never multi-hot and never asserted outside RD.

## Timing
- Reset values:
  - FSM in IDLE.
  - `port_read=0`, `arb_valid=0`, `arb_last=0`, `arb_data=0`, `arb_port=0`.
  - `burst_cnt=0`, `last_grant=NUM_OF_PORTS-1`, so port 0 wins first.
- Reset asserted in any state returns to IDLE on the next edge. A word already read but not yet transferred is dropped.
- Latency: from `port_ready` high in IDLE to `port_read` is 1 cycle. From `port_read` to `arb_valid` is 2 cycles.
- Peak throughput: one word per 3 cycles with `arb_ready` tied high.
- The arbitration decision is combinational from `port_ready` and `last_grant` in IDLE and is registered into `g`.

## Configuration
- `SWITCH_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest-index ready port always wins, and `last_grant` is unused.
- Undefined (default): round-robin; the search starts at `last_grant+1` modulo NUM_OF_PORTS and takes the first ready port.

## Structure
- Package `switch_arb_pkg`:
  - FSM state enum (IDLE, RD, CAP, OUT).
  - Port-index width function ($clog2(NUM_OF_PORTS)).
- Sub-module `rr_pick`: combinational rotate-priority selector.
  - Inputs: request vector and start index.
  - Outputs: grant index and any-grant flag.
  - Also implements fixed priority when the start index is tied to 0.

## Test plan
- Reset mid-OUT (port 2 word pending) → next cycle `arb_valid=0`, `port_read=0`, FSM in IDLE; the next grant goes to port 0 if ready.
- Only port 1 ready, holding 2 words (0xA1, 0xA2), `arb_ready=1` → `port_read=4'b0010` twice. Output is 0xA1 (last=0) then 0xA2 (last=1), `arb_port=1`, 3 cycles apart.
- Port 3 holds 6 words, MAX_BURST=4 → 4 words with the 4th `arb_last=1`; the remaining 2 arrive in a new grant.
- All ports continuously ready, round-robin, 1 word each → grants in order 0,1,2,3,0. With `SWITCH_ARB_FIXED_PRIO_EN` defined, the grant is always 0.
- `arb_ready=0` for 10 cycles in OUT → `arb_data` stable, no `port_read` issued; the transfer completes on the cycle `arb_ready` rises.
- `enable=0` with all ports ready → no `port_read`. `enable` dropped mid-burst → the burst finishes, then no new grant.
